// File: rtl/mbc_pkg.sv
// Shared definitions for the clocked MBC-style bank controller:
// control-space region codes, the RAM unlock key and small sizing helpers.
package mbc_pkg;

   localparam logic [1:0] REG_RAMEN = 2'b00;
   localparam logic [1:0] REG_ROMLO = 2'b01;
   localparam logic [1:0] REG_HI    = 2'b10;
   localparam logic [1:0] REG_MODE  = 2'b11;

   localparam logic [3:0] RAM_EN_KEY = 4'hA;

   // A synchronised write strobe must be low this many cycles to be accepted.
   localparam logic [1:0] MIN_WR_LOW = 2'd2;

   function automatic int cnt_width(input int timeout);
      if (timeout < 1)
         return 1;
      return $clog2(timeout + 1);
   endfunction

   function automatic int aa_width(input int hi_bits);
      return (hi_bits > 0) ? hi_bits : 1;
   endfunction

endpackage

// File: rtl/mbc_wr_sync.sv
// Brings the asynchronous CPU write strobe into the clock domain, filters
// runt pulses and keeps a shadow copy of the address/data seen while low.
module mbc_wr_sync
   import mbc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       n_wr,
   input  logic       a15,
   input  logic       a14,
   input  logic       a13,
   input  logic [7:0] d,
   output logic       commit_stb,
   output logic [2:0] cap_addr,
   output logic [7:0] cap_data
);

   logic       wr_meta_reg;
   logic       wr_s_reg;
   logic [1:0] low_cnt_reg;

   // Preset to the idle (high) level so reset release never looks like a write edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_meta_reg <= 1'b1;
         wr_s_reg    <= 1'b1;
      end else begin
         wr_meta_reg <= n_wr;
         wr_s_reg    <= wr_meta_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         low_cnt_reg <= 2'd0;
      end else if (wr_s_reg) begin
         low_cnt_reg <= 2'd0;
      end else if (low_cnt_reg != 2'd3) begin
         low_cnt_reg <= low_cnt_reg + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_addr <= 3'd0;
         cap_data <= 8'd0;
      end else if (!wr_s_reg) begin
         cap_addr <= {a15, a14, a13};
         cap_data <= d;
      end
   end

   // The low counter clears one cycle after release, so this is a single-cycle pulse.
   assign commit_stb = wr_s_reg && (low_cnt_reg >= MIN_WR_LOW);

endmodule

// File: rtl/mbc_gen_sync.sv
// Clocked MBC1-compatible bank controller with configurable bank widths,
// selectable zero-bank remap and an optional RAM-enable inactivity timeout.
module mbc_gen_sync
   import mbc_pkg::*;
#(
   parameter int LO_BITS     = 5,
   parameter int HI_BITS     = 2,
   parameter int ZERO_REMAP  = 1,
   parameter int RAM_TIMEOUT = 0
) (
   input  logic                          CLK,
   input  logic                          n_RESET,
   input  logic                          n_WR,
   input  logic                          n_CS,
   input  logic                          A15,
   input  logic                          A14,
   input  logic                          A13,
   input  logic [7:0]                    D,
   output logic [LO_BITS-1:0]            RA,
   output logic [aa_width(HI_BITS)-1:0]  AA,
   output logic                          RAM_CS,
   output logic                          n_RAM_CS
);

   logic               commit_stb;
   logic [2:0]         cap_addr;
   logic [7:0]         cap_data;
   logic               wr_cmd;
   logic [1:0]         region;
   logic               key_ok;
   logic               ram_en_reg;
   logic [LO_BITS-1:0] rom_lo_reg;
   logic [LO_BITS-1:0] eff_lo;
   logic               mode_reg;
   logic               unused_data;

   mbc_wr_sync u_wr_sync (
      .clk        (CLK),
      .rst_n      (n_RESET),
      .n_wr       (n_WR),
      .a15        (A15),
      .a14        (A14),
      .a13        (A13),
      .d          (D),
      .commit_stb (commit_stb),
      .cap_addr   (cap_addr),
      .cap_data   (cap_data)
   );

   // Writes with A15 set land in cartridge RAM, not in the control space.
   assign wr_cmd      = commit_stb && !cap_addr[2];
   assign region      = cap_addr[1:0];
   assign key_ok      = (cap_data[3:0] == RAM_EN_KEY);
   assign unused_data = ^cap_data;

   always_ff @(posedge CLK or negedge n_RESET) begin
      if (!n_RESET) begin
         rom_lo_reg <= '0;
         mode_reg   <= 1'b0;
      end else if (wr_cmd) begin
         if (region == REG_ROMLO)
            rom_lo_reg <= cap_data[LO_BITS-1:0];
         if (region == REG_MODE)
            mode_reg <= cap_data[0];
      end
   end

   generate
      if (RAM_TIMEOUT > 0) begin : g_timeout
         localparam int             CW     = cnt_width(RAM_TIMEOUT);
         localparam logic [CW-1:0]  T_LOAD = CW'(RAM_TIMEOUT);
         logic [CW-1:0] cnt_reg;

         // Commit beats RAM activity, which beats the countdown/expiry.
         always_ff @(posedge CLK or negedge n_RESET) begin
            if (!n_RESET) begin
               ram_en_reg <= 1'b0;
               cnt_reg    <= '0;
            end else if (wr_cmd && region == REG_RAMEN) begin
               ram_en_reg <= key_ok;
               cnt_reg    <= key_ok ? T_LOAD : '0;
            end else if (RAM_CS) begin
               cnt_reg <= T_LOAD;
            end else if (ram_en_reg) begin
               if (cnt_reg == '0)
                  ram_en_reg <= 1'b0;
               else
                  cnt_reg <= cnt_reg - 1'b1;
            end
         end
      end else begin : g_no_timeout
         always_ff @(posedge CLK or negedge n_RESET) begin
            if (!n_RESET)
               ram_en_reg <= 1'b0;
            else if (wr_cmd && region == REG_RAMEN)
               ram_en_reg <= key_ok;
         end
      end
   endgenerate

   generate
      if (HI_BITS > 0) begin : g_hi
         logic [HI_BITS-1:0] hi_reg;

         always_ff @(posedge CLK or negedge n_RESET) begin
            if (!n_RESET)
               hi_reg <= '0;
            else if (wr_cmd && region == REG_HI)
               hi_reg <= cap_data[HI_BITS-1:0];
         end

         assign AA = (A14 || mode_reg) ? hi_reg : '0;
      end else begin : g_no_hi
         logic unused_mode;
         assign unused_mode = mode_reg;
         assign AA          = 1'b0;
      end
   endgenerate

   assign eff_lo   = (ZERO_REMAP != 0 && rom_lo_reg == '0) ? LO_BITS'(1) : rom_lo_reg;
   assign RA       = A14 ? eff_lo : '0;
   assign RAM_CS   = ram_en_reg & n_RESET & ~n_CS & A15 & ~A14 & A13;
   assign n_RAM_CS = ~RAM_CS;

endmodule

// File: tb/tb_mbc_gen_sync.sv
// Scoreboard bench: two controller builds share one CPU bus; expectations come
// from an event-level model (register values plus an expiry deadline).
module tb_mbc_gen_sync;

   localparam int TMO      = 16;
   localparam int EXP_GAP  = TMO + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       n_reset, n_wr, n_cs, a15, a14, a13;
   logic [7:0] d;

   logic [4:0] ra_a;
   logic [1:0] aa_a;
   logic       cs_a, ncs_a;
   logic [3:0] ra_b;
   logic [0:0] aa_b;
   logic       cs_b, ncs_b;

   mbc_gen_sync #(.LO_BITS(5), .HI_BITS(2), .ZERO_REMAP(1), .RAM_TIMEOUT(0)) dut_a (
      .CLK(clk), .n_RESET(n_reset), .n_WR(n_wr), .n_CS(n_cs),
      .A15(a15), .A14(a14), .A13(a13), .D(d),
      .RA(ra_a), .AA(aa_a), .RAM_CS(cs_a), .n_RAM_CS(ncs_a)
   );

   mbc_gen_sync #(.LO_BITS(4), .HI_BITS(0), .ZERO_REMAP(0), .RAM_TIMEOUT(TMO)) dut_b (
      .CLK(clk), .n_RESET(n_reset), .n_WR(n_wr), .n_CS(n_cs),
      .A15(a15), .A14(a14), .A13(a13), .D(d),
      .RA(ra_b), .AA(aa_b), .RAM_CS(cs_b), .n_RAM_CS(ncs_b)
   );

   // Reference model state
   int     m_lo_a, m_lo_b, m_hi_a;
   bit     m_mode, m_en_a, m_en_b;
   longint cyc = 0;
   longint deadline = 0;
   longint last_commit = 0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      string      name;
      logic [4:0] ra_a;
      logic [1:0] aa_a;
      logic       cs_a;
      logic [3:0] ra_b;
      logic       cs_b;
   } exp_t;

   exp_t sb[$];

   function automatic int exp_ra(input int lo, input bit remap, input bit sel);
      if (!sel) return 0;
      if (remap && lo == 0) return 1;
      return lo;
   endfunction

   function automatic bit en_b_live();
      return m_en_b && (cyc < deadline);
   endfunction

   function automatic bit ram_sel();
      return n_reset && !n_cs && a15 && !a14 && a13;
   endfunction

   task automatic model_reset();
      m_lo_a = 0; m_lo_b = 0; m_hi_a = 0;
      m_mode = 0; m_en_a = 0; m_en_b = 0;
      deadline = 0;
   endtask

   task automatic apply(input logic [2:0] a, input logic [7:0] v);
      if (a[2]) return;
      last_commit = cyc;
      case (a[1:0])
         2'b00: begin
            m_en_a = (v % 16 == 10);
            m_en_b = m_en_a;
            if (m_en_b) deadline = cyc + EXP_GAP;
         end
         2'b01: begin
            m_lo_a = v % 32;
            m_lo_b = v % 16;
         end
         2'b10: m_hi_a = v % 4;
         default: m_mode = v[0];
      endcase
   endtask

   task automatic push(input string name);
      exp_t e;
      e.name = name;
      e.ra_a = 5'(exp_ra(m_lo_a, 1'b1, a14));
      e.aa_a = (a14 || m_mode) ? 2'(m_hi_a) : 2'd0;
      e.cs_a = m_en_a && ram_sel();
      e.ra_b = 4'(exp_ra(m_lo_b, 1'b0, a14));
      e.cs_b = en_b_live() && ram_sel();
      sb.push_back(e);
   endtask

   // RAM activity seen at an edge pushes the expiry deadline out.
   always @(posedge clk) begin
      bit hit;
      hit = en_b_live() && ram_sel();
      cyc = cyc + 1;
      if (hit) deadline = cyc + EXP_GAP;
   end

   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tests++;
         if ({ra_a, aa_a, cs_a, ncs_a, ra_b, aa_b, cs_b, ncs_b} !==
             {e.ra_a, e.aa_a, e.cs_a, !e.cs_a, e.ra_b, 1'b0, e.cs_b, !e.cs_b}) begin
            n_fail++;
            $display("FAIL %s: got RA_a=%h AA_a=%h CS_a=%b nCS_a=%b RA_b=%h AA_b=%h CS_b=%b nCS_b=%b; want RA_a=%h AA_a=%h CS_a=%b RA_b=%h AA_b=0 CS_b=%b",
                     e.name, ra_a, aa_a, cs_a, ncs_a, ra_b, aa_b, cs_b, ncs_b,
                     e.ra_a, e.aa_a, e.cs_a, e.ra_b, e.cs_b);
         end else begin
            $display("[TB] ok %s: RA_a=%h AA_a=%h CS_a=%b RA_b=%h CS_b=%b",
                     e.name, ra_a, aa_a, cs_a, ra_b, cs_b);
         end
      end
   end

   task automatic idle();
      a15 = 0; a14 = 0; a13 = 0; n_cs = 1;
   endtask

   // Drives a view for half a cycle only, so no clock edge sees it.
   task automatic probe_now(input string name, input logic x15, input logic x14,
                            input logic x13, input logic xcs);
      a15 = x15; a14 = x14; a13 = x13; n_cs = xcs;
      push(name);
      @(negedge clk); #1 idle();
   endtask

   task automatic probe(input string name, input logic x15, input logic x14,
                        input logic x13, input logic xcs);
      @(posedge clk); #1;
      probe_now(name, x15, x14, x13, xcs);
   endtask

   task automatic strobe(input string name);
      @(negedge clk); #1;
      a15 = 1; a14 = 0; a13 = 1; n_cs = 0;
      @(posedge clk); #1 push(name);
      @(negedge clk); #1 idle();
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] v);
      @(negedge clk); #1;
      {a15, a14, a13} = a; d = v; n_wr = 0;
      repeat (3) @(negedge clk);
      #1 n_wr = 1;
      @(posedge clk);
      @(posedge clk); #1;
      probe_now($sformatf("pre  wr %0d<-%02h", a, v), 0, 1, 0, 1);
      @(posedge clk); #1;
      apply(a, v);
      probe_now($sformatf("post wr %0d<-%02h", a, v), 0, 1, 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit, want completion");
      $fatal(1);
   end

   initial begin
      n_reset = 0; n_wr = 1; d = 8'h00;
      idle();
      model_reset();
      repeat (3) @(negedge clk);
      #1 probe_now("reset view A14=1", 0, 1, 0, 1);
      probe_now("reset ram select", 1, 0, 1, 0);
      n_reset = 1;
      probe("after reset A14=1", 0, 1, 0, 1);

      wr(3'b001, 8'h13);
      wr(3'b001, 8'h00);
      wr(3'b001, 8'h20);

      wr(3'b000, 8'h0A);
      probe("ram on", 1, 0, 1, 0);
      wr(3'b000, 8'h00);
      probe("ram off", 1, 0, 1, 0);
      wr(3'b000, 8'h1A);
      probe("ram on nibble", 1, 0, 1, 0);

      wr(3'b010, 8'h03);
      probe("hi mode0 A14=0", 0, 0, 0, 1);
      wr(3'b011, 8'h01);
      probe("hi mode1 A14=0", 0, 0, 0, 1);
      probe("hi mode1 A14=1", 0, 1, 0, 1);
      wr(3'b011, 8'h00);
      probe("hi mode0 A14=1", 0, 1, 0, 1);
      wr(3'b110, 8'h01);
      probe("a15 write ignored", 0, 0, 0, 1);

      // Timeout boundary: still enabled 16 edges after commit, cleared at 17.
      wr(3'b000, 8'h0A);
      repeat (int'(last_commit + TMO - 1 - cyc)) @(posedge clk);
      probe("timeout edge-1", 1, 0, 1, 0);
      probe("timeout expired", 1, 0, 1, 0);

      wr(3'b000, 8'h0A);
      for (int i = 0; i < 5; i++) begin
         repeat (9) @(posedge clk);
         strobe($sformatf("keepalive %0d", i));
      end
      repeat (TMO - 2) @(posedge clk);
      probe("kept alive", 1, 0, 1, 0);

      // Reset in the middle of a write must discard it.
      wr(3'b001, 8'h05);
      @(negedge clk); #1;
      a15 = 0; a14 = 0; a13 = 1; d = 8'h07; n_wr = 0;
      repeat (2) @(negedge clk);
      #1 n_reset = 0;
      model_reset();
      n_wr = 1;
      @(negedge clk); #1;
      probe_now("mid-write reset held", 0, 1, 0, 1);
      #1 n_reset = 1;
      repeat (5) @(posedge clk);
      probe("mid-write reset released", 0, 1, 0, 1);

      wr(3'b001, 8'h06);
      @(negedge clk); #1;
      a15 = 0; a14 = 0; a13 = 1; d = 8'h1F; n_wr = 0;
      @(negedge clk); #1 n_wr = 1;
      repeat (6) @(posedge clk);
      probe("glitch ignored", 0, 1, 0, 1);

      for (int i = 0; i < 40; i++) begin
         logic [2:0] ra;
         logic [7:0] rv;
         ra = {($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
         rv = 8'($urandom);
         if (ra[1:0] == 2'b00 && $urandom_range(0, 1) == 1) rv[3:0] = 4'hA;
         wr(ra, rv);
         repeat ($urandom_range(0, 20)) @(posedge clk);
         if ($urandom_range(0, 2) == 0) strobe($sformatf("rnd strobe %0d", i));
         probe($sformatf("rnd view %0d", i), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom));
      end

      repeat (2) @(posedge clk);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard drain: got %0d pending, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
